// File: rtl/memmu_sr_pkg.sv
// Shared types, constants and the SR byte-address helper for the MemMU SR write path.
package memmu_sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sr_state_t;

    localparam int SR_ADDR_W       = 19;
    localparam int SR_DATA_W       = 64;
    localparam int SR_WORD_BYTES   = 8;
    localparam int DEF_ADDR_BITS_H = 11;
    localparam int DEF_ADDR_BITS_V = 5;
    localparam int N               = DEF_ADDR_BITS_H + DEF_ADDR_BITS_V;
    localparam int ENTRIES         = 1 << N;

    // Byte address of SR word idx: base + idx * SR_WORD_BYTES, wrapping at 2^32.
    function automatic logic [31:0] sr_byte_addr(input logic [31:0] base,
                                                 input logic [SR_ADDR_W-1:0] idx);
        sr_byte_addr = base + {10'd0, idx, 3'b000};
    endfunction

endpackage

// File: rtl/memmu_sr_wfifo.sv
// Synchronous write FIFO holding {sr_address, sr_payload} entries with an occupancy count.
module memmu_sr_wfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 83
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != L_FULL);
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/memmu_sr_write_scheduler.sv
// Frame-level write controller: zero-sweeps the SR region at frame start, then forwards
// SR address/payload words to the 64-bit memory write port in acceptance order.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1.
// Once o_MEM_wvalid is raised, it and o_MEM_waddr/o_MEM_wdata hold until that transfer.
module memmu_sr_write_scheduler
    import memmu_sr_pkg::*;
#(
    parameter int          NUMBER_OF_ADDR_BITS_H = DEF_ADDR_BITS_H,
    parameter int          NUMBER_OF_ADDR_BITS_V = DEF_ADDR_BITS_V,
    parameter int          FIFO_DEPTH            = 4,
    parameter logic [31:0] BASE_ADDR             = 32'h0000_0000
) (
    input  logic                 i_SYSTEM_clk,
    input  logic                 i_SYSTEM_rst,
    input  logic                 i_CTRL_frameStart,
    input  logic                 i_CTRL_frameEnd,
    input  logic                 i_SIU_valid,
    output logic                 o_SIU_ready,
    input  logic [SR_ADDR_W-1:0] i_SR_address,
    input  logic [SR_DATA_W-1:0] i_SR_payload,
    output logic                 o_SR_enable,
    output logic                 o_MEM_wvalid,
    input  logic                 i_MEM_wready,
    output logic [31:0]          o_MEM_waddr,
    output logic [SR_DATA_W-1:0] o_MEM_wdata,
    output logic                 o_CTRL_busy,
    output logic                 o_CTRL_frameDone,
    output logic [31:0]          o_CTRL_pointCount
);

    localparam int L_N  = NUMBER_OF_ADDR_BITS_H + NUMBER_OF_ADDR_BITS_V;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int SW   = CW + 1;
    localparam int FW   = SR_ADDR_W + SR_DATA_W;
    localparam logic [SW-1:0]        L_DEPTH     = SW'(FIFO_DEPTH);
    localparam logic [SR_ADDR_W-1:0] L_ADDR_MASK = SR_ADDR_W'((64'd1 << L_N) - 64'd1);

    sr_state_t      r_state;
    logic           r_next_clear;
    logic           r_done_owed;
    logic           r_inflight;
    logic           r_frame_done;
    logic [L_N-1:0] r_sweep_idx;
    logic [31:0]    r_point_count;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_fifo_empty;
    logic                 w_head_valid;
    logic [CW-1:0]        w_fifo_count;
    logic [FW-1:0]        w_fifo_dout;
    logic [SR_ADDR_W-1:0] w_head_addr;
    logic [SR_DATA_W-1:0] w_head_payload;

    // The in-flight point already owns a FIFO slot, so the push one cycle later never overflows.
    assign w_ready        = (r_state == ST_RUN) &&
                            (({1'b0, w_fifo_count} + SW'(r_inflight)) < L_DEPTH);
    assign w_accept       = w_ready && i_SIU_valid;
    assign w_head_valid   = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_fifo_empty;
    assign w_pop          = w_head_valid && i_MEM_wready;
    assign w_head_addr    = w_fifo_dout[FW-1:SR_DATA_W];
    assign w_head_payload = w_fifo_dout[SR_DATA_W-1:0];

    assign o_SIU_ready       = w_ready;
    assign o_SR_enable       = w_accept;
    assign o_MEM_wvalid      = (r_state == ST_CLEAR) || w_head_valid;
    assign o_CTRL_busy       = (r_state != ST_IDLE);
    assign o_CTRL_frameDone  = r_frame_done;
    assign o_CTRL_pointCount = r_point_count;

    memmu_sr_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_wfifo (
        .i_clk   (i_SYSTEM_clk),
        .i_rst   (i_SYSTEM_rst),
        .i_push  (r_inflight),
        .i_din   ({i_SR_address, i_SR_payload}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Memory port mux: zero sweep during CLEAR, FIFO head otherwise; zero when idle.
    always_comb begin
        o_MEM_waddr = '0;
        o_MEM_wdata = '0;
        if (r_state == ST_CLEAR) begin
            o_MEM_waddr = sr_byte_addr(BASE_ADDR, SR_ADDR_W'(r_sweep_idx));
        end else if (w_head_valid) begin
            o_MEM_waddr = sr_byte_addr(BASE_ADDR, w_head_addr & L_ADDR_MASK);
            o_MEM_wdata = w_head_payload;
        end
    end

    // Frame sequencing, sweep counter, in-flight bit, point counter and done pulse.
    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            r_state       <= ST_IDLE;
            r_next_clear  <= 1'b0;
            r_done_owed   <= 1'b0;
            r_inflight    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sweep_idx   <= '0;
            r_point_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            // The SR stage registers an accepted point for exactly one cycle before it is pushed.
            r_inflight   <= w_accept;
            if (w_pop && (r_point_count != '1)) begin
                r_point_count <= r_point_count + 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_CTRL_frameStart) begin
                        r_state       <= ST_CLEAR;
                        r_sweep_idx   <= '0;
                        r_point_count <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (i_MEM_wready) begin
                        r_sweep_idx <= r_sweep_idx + L_N'(1);
                        if (r_sweep_idx == '1) r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_CTRL_frameStart || i_CTRL_frameEnd) begin
                        r_state      <= ST_DRAIN;
                        r_next_clear <= i_CTRL_frameStart;
                        r_done_owed  <= i_CTRL_frameEnd;
                    end
                end
                ST_DRAIN: begin
                    if (!r_inflight && w_fifo_empty) begin
                        r_frame_done <= r_done_owed;
                        if (r_next_clear) begin
                            r_state       <= ST_CLEAR;
                            r_sweep_idx   <= '0;
                            r_point_count <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memmu_sr_write_scheduler.sv
// Bench for memmu_sr_write_scheduler (H=3, V=2, 32 entries, FIFO depth 4, base 0x1000).
// The reference model is an ordered list of expected memory writes: a zero sweep is
// appended whenever a frame start is issued, and every accepted point appends its write.
module tb_memmu_sr_write_scheduler;

    localparam int          ENT   = 32;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          QW    = 97;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        siu_valid = 1'b0;
    logic        mem_wready = 1'b0;
    logic [18:0] sr_address = '0;
    logic [63:0] sr_payload = '0;

    logic        o_SIU_ready;
    logic        o_SR_enable;
    logic        o_MEM_wvalid;
    logic [31:0] o_MEM_waddr;
    logic [63:0] o_MEM_wdata;
    logic        o_CTRL_busy;
    logic        o_CTRL_frameDone;
    logic [31:0] o_CTRL_pointCount;

    // Point currently offered by the SIU.
    logic [18:0] pt_addr = '0;
    logic [63:0] pt_payload = '0;

    // Scoreboard: {is_point, byte address, data} in required write order.
    logic [QW-1:0] exp_q[$];
    logic [QW-1:0] mon_e;
    int          n_checks = 0;
    int          n_fails = 0;
    int          n_done = 0;
    int          exp_done = 0;
    int          n_points_written = 0;
    int          n_acc = 0;
    logic        acc_now = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] stall_addr = '0;
    logic [63:0] stall_data = '0;

    memmu_sr_write_scheduler #(
        .NUMBER_OF_ADDR_BITS_H (3),
        .NUMBER_OF_ADDR_BITS_V (2),
        .FIFO_DEPTH            (4),
        .BASE_ADDR             (BASE)
    ) dut (
        .i_SYSTEM_clk      (clk),
        .i_SYSTEM_rst      (rst),
        .i_CTRL_frameStart (frame_start),
        .i_CTRL_frameEnd   (frame_end),
        .i_SIU_valid       (siu_valid),
        .o_SIU_ready       (o_SIU_ready),
        .i_SR_address      (sr_address),
        .i_SR_payload      (sr_payload),
        .o_SR_enable       (o_SR_enable),
        .o_MEM_wvalid      (o_MEM_wvalid),
        .i_MEM_wready      (mem_wready),
        .o_MEM_waddr       (o_MEM_waddr),
        .o_MEM_wdata       (o_MEM_wdata),
        .o_CTRL_busy       (o_CTRL_busy),
        .o_CTRL_frameDone  (o_CTRL_frameDone),
        .o_CTRL_pointCount (o_CTRL_pointCount)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model of the SR stage: address/payload registered one cycle after acceptance.
    always @(posedge clk) begin
        if (acc_now) begin
            sr_address <= pt_addr;
            sr_payload <= pt_payload;
        end
    end

    // Monitor, sampled mid-cycle: values seen here are what the next rising edge uses.
    always @(negedge clk) begin
        if (!rst) begin
            if (siu_valid) check("sr_enable", o_SR_enable, o_SIU_ready);
            if (prev_stall) begin
                check("wvalid_hold", o_MEM_wvalid, 1'b1);
                check("waddr_hold", o_MEM_waddr, stall_addr);
                check("wdata_hold", o_MEM_wdata, stall_data);
            end
            if (o_MEM_wvalid && mem_wready) begin
                check("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("waddr", o_MEM_waddr, mon_e[95:64]);
                    check("wdata", o_MEM_wdata, mon_e[63:0]);
                    if (mon_e[96]) n_points_written++;
                    else           n_points_written = 0;
                end
            end
            prev_stall = o_MEM_wvalid && !mem_wready;
            stall_addr = o_MEM_waddr;
            stall_data = o_MEM_wdata;
            acc_now = siu_valid && o_SIU_ready;
            if (acc_now) begin
                exp_q.push_back({1'b1, BASE + 32'((int'(pt_addr) % ENT) * 8), pt_payload});
            end
            if (o_CTRL_frameDone) begin
                n_done++;
                check("done_width", prev_done, 1'b0);
            end
            prev_done = o_CTRL_frameDone;
        end else begin
            prev_stall = 1'b0;
            acc_now    = 1'b0;
            prev_done  = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_point();
        pt_addr    = 19'($urandom);
        pt_payload = {$urandom, $urandom};
    endtask

    task automatic frame_strobe(input logic s, input logic e);
        frame_start = s;
        frame_end   = e;
        @(posedge clk);
        if (s) begin
            for (int i = 0; i < ENT; i++) exp_q.push_back({1'b0, BASE + 32'(i * 8), 64'd0});
        end
        if (e) exp_done++;
        #1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        if (acc_now) begin
            n_acc++;
            new_point();
            siu_valid = 1'b0;
        end
    endtask

    task automatic send_fixed(input logic [18:0] a, input logic [63:0] p);
        int left = 50;
        pt_addr    = a;
        pt_payload = p;
        siu_valid  = 1'b1;
        do begin
            tick();
            left--;
        end while (!acc_now && left > 0);
        check("send_accepted", acc_now, 1'b1);
        siu_valid = 1'b0;
    endtask

    // Random SIU traffic; valid holds until accepted. Percent probabilities.
    task automatic stream(input int ncyc, input int vp, input int wp);
        for (int c = 0; c < ncyc; c++) begin
            if (!siu_valid) siu_valid = (int'($urandom_range(99)) < vp);
            mem_wready = (int'($urandom_range(99)) < wp);
            tick();
            if (acc_now) begin
                n_acc++;
                new_point();
                siu_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int left = budget;
        while (exp_q.size() != 0 && left > 0) begin
            tick();
            left--;
        end
        check({tag, "_timeout"}, exp_q.size() != 0, 1'b0);
        tick();
        tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int left = budget;
        while (o_CTRL_busy && left > 0) begin
            tick();
            left--;
        end
        check({tag, "_timeout"}, o_CTRL_busy, 1'b0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wvalid"}, o_MEM_wvalid, 1'b0);
        check({tag, "_waddr"}, o_MEM_waddr, 32'd0);
        check({tag, "_wdata"}, o_MEM_wdata, 64'd0);
        check({tag, "_ready"}, o_SIU_ready, 1'b0);
        check({tag, "_sr_en"}, o_SR_enable, 1'b0);
        check({tag, "_busy"}, o_CTRL_busy, 1'b0);
        check({tag, "_done"}, o_CTRL_frameDone, 1'b0);
        check({tag, "_count"}, o_CTRL_pointCount, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic s;
        logic e;
        logic idle;
        int kind;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: full zero sweep, back-to-back, then RUN
        mem_wready = 1'b1;
        frame_strobe(1'b1, 1'b0);
        for (int i = 0; i < ENT; i++) begin
            check("clear_wvalid", o_MEM_wvalid, 1'b1);
            check("clear_busy", o_CTRL_busy, 1'b1);
            tick();
        end
        check("clear_done_in_32", exp_q.size(), 0);
        check("run_wvalid_idle", o_MEM_wvalid, 1'b0);
        check("run_ready", o_SIU_ready, 1'b1);
        check("run_busy", o_CTRL_busy, 1'b1);

        // 2: six points to SR address 5
        for (int k = 0; k < 6; k++) send_fixed(19'd5, 64'hA5A5_0000_0000_0000 | 64'(k));
        wait_empty("t2", 50);
        check("t2_count", o_CTRL_pointCount, 32'd6);
        check("t2_model_count", o_CTRL_pointCount, 32'(n_points_written));

        // 3: back-pressure, valid held for 12 cycles
        n_acc = 0;
        stream(12, 100, 0);
        check("t3_accepted", n_acc, 4);
        check("t3_ready_low", o_SIU_ready, 1'b0);
        check("t3_wvalid", o_MEM_wvalid, 1'b1);
        siu_valid  = 1'b0;
        mem_wready = 1'b1;
        wait_empty("t3", 50);
        check("t3_count", o_CTRL_pointCount, 32'd10);

        // 4: three pending points (one with address bits above N-1), then frame end
        mem_wready = 1'b0;
        send_fixed(19'h7FFE3, 64'h1111_2222_3333_4444);
        send_fixed(19'd31, 64'hDEAD_BEEF_0000_0001);
        send_fixed(19'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        frame_strobe(1'b0, 1'b1);
        check("t4_ready_low", o_SIU_ready, 1'b0);
        check("t4_busy", o_CTRL_busy, 1'b1);
        mem_wready = 1'b1;
        wait_idle("t4", 50);
        check("t4_done", n_done, exp_done);
        check("t4_busy_low", o_CTRL_busy, 1'b0);
        check("t4_q_empty", exp_q.size(), 0);
        check("t4_count", o_CTRL_pointCount, 32'd13);

        // 5: both strobes in one cycle while RUN, with an acceptance in that cycle
        frame_strobe(1'b1, 1'b0);
        wait_empty("t5_clear", 100);
        mem_wready = 1'b0;
        send_fixed(19'd7, 64'h0000_0000_0000_0A07);
        send_fixed(19'd9, 64'h0000_0000_0000_0A09);
        pt_addr    = 19'd12;
        pt_payload = 64'h0000_0000_0000_0A0C;
        siu_valid  = 1'b1;
        frame_strobe(1'b1, 1'b1);
        check("t5_strobe_accept", acc_now, 1'b1);
        siu_valid  = 1'b0;
        mem_wready = 1'b1;
        wait_empty("t5", 200);
        check("t5_done", n_done, exp_done);
        check("t5_count_zero", o_CTRL_pointCount, 32'd0);
        check("t5_busy", o_CTRL_busy, 1'b1);
        check("t5_ready", o_SIU_ready, 1'b1);

        // 6: reset during the sweep at index 10 with the memory stalled
        frame_strobe(1'b0, 1'b1);
        wait_idle("t6_end", 50);
        check("t6_end_done", n_done, exp_done);
        mem_wready = 1'b1;
        frame_strobe(1'b1, 1'b0);
        repeat (10) tick();
        mem_wready = 1'b0;
        tick();
        check("t6_idx10_addr", o_MEM_waddr, BASE + 32'd80);
        check("t6_idx10_wvalid", o_MEM_wvalid, 1'b1);
        rst = 1'b1;
        tick();
        check_all_zero("t6_reset");
        rst = 1'b0;
        exp_q.delete();
        n_points_written = 0;
        tick();
        check_all_zero("t6_after");
        mem_wready = 1'b1;
        frame_strobe(1'b1, 1'b0);
        check("t6_restart_addr", o_MEM_waddr, BASE);
        wait_empty("t6_restart", 100);

        // Randomized frames
        idle = 1'b0;
        for (int f = 0; f < 6; f++) begin
            if (idle) begin
                siu_valid  = 1'b0;
                mem_wready = 1'b1;
                frame_strobe(1'b1, 1'b0);
                wait_empty("rnd_clear", 200);
            end
            stream(150, 60, 70);
            kind = int'($urandom_range(2));
            s = (kind != 0);
            e = (kind != 1);
            frame_strobe(s, e);
            stream(40, 50, 60);
            siu_valid  = 1'b0;
            mem_wready = 1'b1;
            wait_empty("rnd_drain", 400);
            if (!s) wait_idle("rnd_idle", 50);
            check("rnd_done", n_done, exp_done);
            check("rnd_count", o_CTRL_pointCount, 32'(n_points_written));
            check("rnd_busy", o_CTRL_busy, s);
            idle = !s;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
